scan_pe_scheduler: RTL

//  Sequencer for the SCAN polar-decoder PE. Walks the SCAN factor graph one leaf pair at a time,

---
 rtl/polar_pkg.sv | 17 +
 rtl/polar_ctz.sv | 29 ++
 rtl/scan_pe_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/polar_pkg.sv
// Shared op codes for the SCAN PE and the scheduler FSM state encoding.
package polar_pkg;

  localparam logic [3:0] TYPE1FUN  = 4'b0000;
  localparam logic [3:0] TYPE2FUN  = 4'b0001;
  localparam logic [3:0] BOTTOMFUN = 4'b0010;
  localparam logic [3:0] TYPE3FUN  = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DOWN   = 3'd1,
    ST_BOTTOM = 3'd2,
    ST_UP     = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/polar_ctz.sv
// Combinational count-trailing-zeros; an all-zero input returns W.
module polar_ctz #(
  parameter int W  = 6,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_x,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] w_cnt;
  logic          w_found;

  // Lowest set bit wins.
  always_comb begin
    w_cnt   = CW'(W);
    w_found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!w_found && i_x[i]) begin
        w_cnt   = CW'(i);
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_cnt = w_cnt;

endmodule

// File: rtl/scan_pe_scheduler.sv
// SCAN polar-decoder PE sequencer: walks the factor graph one leaf pair per phase,
// issuing one registered op per non-held cycle and a one-cycle-delayed write-back copy.
module scan_pe_scheduler
  import polar_pkg::*;
#(
  parameter int N    = 128,
  parameter int ITER = 2,
  localparam int M   = $clog2(N) - 1,
  localparam int SW  = $clog2(M + 1),
  localparam int PW  = $clog2(N) - 1,
  localparam int IW  = $clog2(ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  info_mask,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          op_valid,
  output logic [3:0]    op_type,
  output logic [SW-1:0] op_stage,
  output logic [PW-1:0] op_phase,
  output logic [IW-1:0] op_iter,
  output logic          pe_type1,
  output logic          pe_type2,
  output logic          wb_valid,
  output logic [3:0]    wb_type,
  output logic [SW-1:0] wb_stage,
  output logic [PW-1:0] wb_phase
);

  state_t        r_state;
  logic [SW-1:0] r_k;
  logic [PW-1:0] r_p;
  logic [IW-1:0] r_iter;
  logic [N-1:0]  r_mask;

  logic          r_busy, r_done, r_op_valid, r_pe1, r_pe2, r_wb_valid;
  logic [3:0]    r_op_type, r_wb_type;
  logic [SW-1:0] r_op_stage, r_wb_stage;
  logic [PW-1:0] r_op_phase, r_wb_phase;
  logic [IW-1:0] r_op_iter;

  logic [PW-1:0] w_p_inc;
  logic [SW-1:0] w_ctz;
  logic [PW:0]   w_p_ext;
  logic          w_p_last, w_iter_last;
  state_t        w_nx_state;
  logic [SW-1:0] w_nx_k;
  logic [PW-1:0] w_nx_p;
  logic [IW-1:0] w_nx_iter;

  assign w_p_inc     = r_p + PW'(1);
  assign w_p_ext     = {1'b0, r_p};
  assign w_p_last    = (r_p == PW'(N / 2 - 1));
  assign w_iter_last = (r_iter == IW'(ITER - 1));

  polar_ctz #(.W(PW), .CW(SW)) u_ctz (
    .i_x   (w_p_inc),
    .o_cnt (w_ctz)
  );

  // Phase advance taken after the last op of a leaf pair (BOTTOM or final UP).
  always_comb begin
    w_nx_state = ST_DONE;
    w_nx_k     = r_k;
    w_nx_p     = r_p;
    w_nx_iter  = r_iter;
    if (!w_p_last) begin
      w_nx_state = ST_DOWN;
      w_nx_p     = w_p_inc;
      w_nx_k     = w_ctz + SW'(1);
    end else if (!w_iter_last) begin
      w_nx_state = ST_DOWN;
      w_nx_p     = {PW{1'b0}};
      w_nx_k     = SW'(M);
      w_nx_iter  = r_iter + IW'(1);
    end else begin
      w_nx_state = ST_DONE;
    end
  end

  // Sequencing FSM with registered op outputs and the write-back stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_k        <= {SW{1'b0}};
      r_p        <= {PW{1'b0}};
      r_iter     <= {IW{1'b0}};
      r_mask     <= {N{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_op_valid <= 1'b0;
      r_op_type  <= 4'b0000;
      r_op_stage <= {SW{1'b0}};
      r_op_phase <= {PW{1'b0}};
      r_op_iter  <= {IW{1'b0}};
      r_pe1      <= 1'b0;
      r_pe2      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_type  <= 4'b0000;
      r_wb_stage <= {SW{1'b0}};
      r_wb_phase <= {PW{1'b0}};
    end else begin
      r_op_valid <= 1'b0;
      r_op_type  <= 4'b0000;
      r_op_stage <= {SW{1'b0}};
      r_pe1      <= 1'b0;
      r_pe2      <= 1'b0;
      r_done     <= 1'b0;
      r_wb_valid <= r_op_valid;
      r_wb_type  <= r_op_type;
      r_wb_stage <= r_op_stage;
      r_wb_phase <= r_op_phase;
      case (r_state)
        ST_IDLE: begin
          r_busy <= start;
          if (start) begin
            r_mask  <= info_mask;
            r_p     <= {PW{1'b0}};
            r_iter  <= {IW{1'b0}};
            r_k     <= SW'(M);
            r_state <= ST_DOWN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DOWN: begin
          if (!hold) begin
            r_op_valid <= 1'b1;
            r_op_type  <= w_p_ext[r_k - SW'(1)] ? TYPE2FUN : TYPE1FUN;
            r_op_stage <= r_k;
            r_op_phase <= r_p;
            r_op_iter  <= r_iter;
            if (r_k == SW'(1)) begin
              r_state <= ST_BOTTOM;
            end else begin
              r_k <= r_k - SW'(1);
            end
          end else begin
            r_state <= r_state;
          end
        end
        ST_BOTTOM: begin
          if (!hold) begin
            r_op_valid <= 1'b1;
            r_op_type  <= BOTTOMFUN;
            r_op_phase <= r_p;
            r_op_iter  <= r_iter;
            r_pe1      <= r_mask[{r_p, 1'b0}];
            r_pe2      <= r_mask[{r_p, 1'b1}];
            if (r_p[0]) begin
              r_k     <= SW'(1);
              r_state <= ST_UP;
            end else begin
              r_state <= w_nx_state;
              r_k     <= w_nx_k;
              r_p     <= w_nx_p;
              r_iter  <= w_nx_iter;
            end
          end else begin
            r_state <= r_state;
          end
        end
        ST_UP: begin
          if (!hold) begin
            r_op_valid <= 1'b1;
            r_op_type  <= TYPE3FUN;
            r_op_stage <= r_k;
            r_op_phase <= r_p;
            r_op_iter  <= r_iter;
            // Climb while the current stage's partner subtree is also complete.
            if ((r_k < SW'(M)) && w_p_ext[r_k]) begin
              r_k <= r_k + SW'(1);
            end else begin
              r_state <= w_nx_state;
              r_k     <= w_nx_k;
              r_p     <= w_nx_p;
              r_iter  <= w_nx_iter;
            end
          end else begin
            r_state <= r_state;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign op_valid = r_op_valid;
  assign op_type  = r_op_type;
  assign op_stage = r_op_stage;
  assign op_phase = r_op_phase;
  assign op_iter  = r_op_iter;
  assign pe_type1 = r_pe1;
  assign pe_type2 = r_pe2;
  assign wb_valid = r_wb_valid;
  assign wb_type  = r_wb_type;
  assign wb_stage = r_wb_stage;
  assign wb_phase = r_wb_phase;

endmodule
